// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_pkg
// Purpose  : Shared types, constants and byte-lane helpers for the dmem_resp
//            data-memory responder.
// Contents : state_t   - responder FSM states (IDLE, ACCESS, DONE)
//            c_CNT_W   - wait-state counter width
//            lane_get  - extract byte lane 'sel' of a 32-bit word
//            lane_put  - replace byte lane 'sel' of a 32-bit word
// Revision : 1.0 - initial release
// ============================================================================
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int c_CNT_W = 4;

    function automatic logic [7:0] lane_get(input logic [31:0] word,
                                            input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] word,
                                             input logic [1:0]  sel,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (sel)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_if
// Purpose  : Load/store bus between the core (master) and dmem_resp (slave).
// Signals  : MemRead, MemWrite, LSB, DataAdr[31:0], WriteData[31:0]
//              - request side, driven by the master
//            ReadData[31:0], Ready, Err
//              - response side, driven by the slave
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_resp_if;
    import dmem_resp_pkg::*;

    logic        MemRead;
    logic        MemWrite;
    logic        LSB;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Err;

    modport master (
        output MemRead, MemWrite, LSB, DataAdr, WriteData,
        input  ReadData, Ready, Err
    );

    modport slave (
        input  MemRead, MemWrite, LSB, DataAdr, WriteData,
        output ReadData, Ready, Err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_ram
// Purpose  : DEPTH x 32 word array, synchronous write with word enable and a
//            registered read port that samples i_addr every cycle.
// Ports    : clk      - clock
//            i_we     - word write enable
//            i_addr   - word index
//            i_wdata  - write word
//            o_rdata  - word at the address sampled on the previous edge
//                       (read-before-write on a colliding edge)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp_ram
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // Contents are deliberately left uninitialised and untouched by reset.
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp
// Purpose  : Multi-cycle data-memory responder with Ready handshake, word and
//            byte loads/stores, and out-of-range / dual-strobe error flag.
// Ports    : clk    - clock, rising edge
//            reset  - synchronous, active-high
//            bus    - dmem_resp_if.slave (MemRead, MemWrite, LSB, DataAdr,
//                     WriteData in; ReadData, Ready, Err out)
// Params   : DEPTH        - RAM words (power of two, >= 4)
//            WAIT_CYCLES  - extra wait states per access (0..15)
// Config   : DMEM_RESP_BYTE_EN - when defined, LSB selects byte loads and
//            read-modify-write byte stores; otherwise every access is a word.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    dmem_resp_if.slave  bus
);

    localparam int                 c_AW        = $clog2(DEPTH);
    localparam logic [29:0]        c_DEPTH_IDX = 30'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_WAIT      = c_CNT_W'(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_AW-1:0]     r_idx;
    logic [31:0]         r_wdata;
    logic                r_write;
    logic                r_oor;
    logic                r_err;
    logic [31:0]         r_rdata;

    logic                w_req;
    logic                w_oor_in;
    logic                w_we;
    logic [c_AW-1:0]     w_ram_addr;
    logic [31:0]         w_ram_rdata;
    logic [31:0]         w_ram_wdata;
    logic [31:0]         w_load_data;

    assign w_req    = bus.MemRead | bus.MemWrite;
    assign w_oor_in = (bus.DataAdr[31:2] >= c_DEPTH_IDX);

    // The RAM read port follows the live bus address while idle so the old
    // word is already registered by the first ACCESS cycle; that is what
    // lets a byte store merge and commit even with zero wait states.
    assign w_ram_addr = (r_state == IDLE) ? bus.DataAdr[c_AW+1:2] : r_idx;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_we         = 1'b0;
        bus.Ready    = 1'b0;
        bus.Err      = 1'b0;
        bus.ReadData = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    // Gating with reset keeps an aborted store from committing.
                    w_we        = r_write & ~r_oor & ~reset;
                end
            end
            DONE: begin
                bus.Ready    = 1'b1;
                bus.Err      = r_err;
                bus.ReadData = r_rdata;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and load data register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_cnt   <= c_WAIT;
                        r_idx   <= bus.DataAdr[c_AW+1:2];
                        r_wdata <= bus.WriteData;
                        r_write <= bus.MemWrite;
                        r_oor   <= w_oor_in;
                        r_err   <= w_oor_in | (bus.MemRead & bus.MemWrite);
                    end
                end
                ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        r_rdata <= (r_oor | r_write) ? '0 : w_load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte lane handling
    // ------------------------------------------------------------------
`ifdef DMEM_RESP_BYTE_EN
    logic       r_lsb;
    logic [1:0] r_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lsb  <= 1'b0;
            r_lane <= 2'd0;
        end else if ((r_state == IDLE) && w_req) begin
            r_lsb  <= bus.LSB;
            r_lane <= bus.DataAdr[1:0];
        end
    end

    assign w_ram_wdata = r_lsb ? lane_put(w_ram_rdata, r_lane, r_wdata[7:0])
                               : r_wdata;
    assign w_load_data = r_lsb ? {24'h0, lane_get(w_ram_rdata, r_lane)}
                               : w_ram_rdata;
`else
    logic w_unused;

    assign w_ram_wdata = r_wdata;
    assign w_load_data = w_ram_rdata;
    assign w_unused    = &{1'b0, bus.LSB, bus.DataAdr[1:0]};
`endif

    dmem_resp_ram #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_resp
// Purpose  : Self-checking bench for dmem_resp. Three instances with
//            WAIT_CYCLES = 0, 3 and 2 share one clock; each access pushes its
//            expected response to a scoreboard that is popped on Ready.
// Config   : DMEM_RESP_BYTE_EN selects byte-lane or word-only expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    typedef struct {
        int          which;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        bit          chk_data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3, rst2;

    dmem_resp_if if0();
    dmem_resp_if if3();
    dmem_resp_if if2();

    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));
    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(if3.slave));
    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .reset(rst2), .bus(if2.slave));

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] mdl [int];
    exp_t        sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int w);
        case (w)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic ready_of(input int w);
        case (w)
            0:       return if0.Ready;
            1:       return if3.Ready;
            default: return if2.Ready;
        endcase
    endfunction

    function automatic logic err_of(input int w);
        case (w)
            0:       return if0.Err;
            1:       return if3.Err;
            default: return if2.Err;
        endcase
    endfunction

    function automatic logic [31:0] rdata_of(input int w);
        case (w)
            0:       return if0.ReadData;
            1:       return if3.ReadData;
            default: return if2.ReadData;
        endcase
    endfunction

    task automatic drive(input int w, input logic rd, input logic wr, input logic lsb,
                         input logic [31:0] adr, input logic [31:0] wd);
        case (w)
            0: begin
                if0.MemRead = rd; if0.MemWrite = wr; if0.LSB = lsb;
                if0.DataAdr = adr; if0.WriteData = wd;
            end
            1: begin
                if3.MemRead = rd; if3.MemWrite = wr; if3.LSB = lsb;
                if3.DataAdr = adr; if3.WriteData = wd;
            end
            default: begin
                if2.MemRead = rd; if2.MemWrite = wr; if2.LSB = lsb;
                if2.DataAdr = adr; if2.WriteData = wd;
            end
        endcase
    endtask

    // Called at a falling edge; the request is live for the next rising edge.
    task automatic access(input int w, input logic rd, input logic wr, input logic lsb,
                          input logic [31:0] adr, input logic [31:0] wd, input string tag);
        exp_t        e;
        int          key;
        int          n;
        bit          got;
        bit          use_lsb;
        logic        oor;
        logic [1:0]  a;
        logic [31:0] word;

        use_lsb = 1'b0;
`ifdef DMEM_RESP_BYTE_EN
        use_lsb = lsb;
`endif
        oor  = (adr[31:2] >= 30'd64);
        a    = adr[1:0];
        key  = w * 4096 + int'(adr[7:2]);
        word = 32'h0;

        e.which    = w;
        e.err      = oor | (rd & wr);
        e.lat      = 2 + wait_of(w);
        e.rdata    = 32'h0;
        e.chk_data = !wr;
        if (wr) begin
            if (!oor) begin
                if (mdl.exists(key)) word = mdl[key];
                if (use_lsb) word[8*a +: 8] = wd[7:0];
                else         word = wd;
                mdl[key] = word;
            end
        end else if (!oor) begin
            word    = mdl[key];
            e.rdata = use_lsb ? {24'h0, word[8*a +: 8]} : word;
        end
        sb.push_back(e);

        drive(w, rd, wr, lsb, adr, wd);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready_of(w)) got = 1'b1;
            else check({tag, " rdata-before-ready"}, rdata_of(w), 32'h0);
        end
        drive(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        e = sb.pop_front();
        check({tag, " ready-seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " latency"}, 32'(n), 32'(e.lat));
            check({tag, " err"}, 32'(err_of(e.which)), 32'(e.err));
            if (e.chk_data) check({tag, " rdata"}, rdata_of(e.which), e.rdata);
        end

        @(negedge clk);
        check({tag, " ready-pulse-end"}, 32'(ready_of(w)), 32'd0);
        check({tag, " rdata-after-ready"}, rdata_of(w), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            check($sformatf("reset ready dut%0d", w), 32'(ready_of(w)), 32'd0);
            check($sformatf("reset err dut%0d", w), 32'(err_of(w)), 32'd0);
            check($sformatf("reset rdata dut%0d", w), rdata_of(w), 32'h0);
        end

        // Zero wait states: word traffic, byte lanes, errors.
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007, "w0 store 0x64");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0,         "w0 load 0x64");
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0102_0304, "w0 store 0x0");
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'hAABB_CCDD, "w0 store 0x20");
        access(0, 1'b0, 1'b1, 1'b1, 32'h0000_0022, 32'hFFFF_FF11, "w0 bstore 0x22");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         "w0 load 0x20");
        access(0, 1'b1, 1'b0, 1'b1, 32'h0000_0023, 32'h0,         "w0 bload 0x23");
        access(0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0,         "w0 bload 0x20");
        access(0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0005, "w0 both 0x8");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,         "w0 load 0x8");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         "w0 oor load");
        access(0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, "w0 oor store");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         "w0 reload 0x0");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         "w0 reload 0x20");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0,         "w0 reload 0x64");
        access(0, 1'b1, 1'b0, 1'b0, 32'h0000_00FC, 32'h0,         "w0 unwritten-skip");

        // Three wait states.
        access(1, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, "w3 store 0x40");
        access(1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         "w3 load 0x40");
        access(1, 1'b1, 1'b0, 1'b1, 32'h0000_0041, 32'h0,         "w3 bload 0x41");

        // Reset during the final ACCESS cycle of a store, WAIT_CYCLES=2.
        access(2, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_1234, "w2 prior store");
        drive(2, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0009);
        repeat (3) begin
            @(negedge clk);
            check("w2 abort no ready", 32'(ready_of(2)), 32'd0);
        end
        rst2 = 1'b1;
        @(negedge clk);
        check("w2 abort ready after reset", 32'(ready_of(2)), 32'd0);
        rst2 = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        access(2, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0,         "w2 reload 0xC");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_resp.md
# dmem_resp

Multi-cycle data-memory responder: the memory end of the processor's load/store interface (MemWrite/DataAdr/WriteData/ReadData/LSB), extended with a read strobe and a Ready handshake so the core can stall on wait states. It holds a word-addressed RAM, serves word and byte loads and stores, and flags out-of-range accesses. It replaces the zero-latency combinational data memory once the core gains a stall input.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 0: extra wait states per access, 0..15.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- LSB  in  1  byte access (LDRB/STRB) when 1, word access when 0.
- DataAdr  in  32  byte address.
- WriteData  in  32  store data; byte stores use [7:0].
- ReadData  out  32  load data; valid only while Ready=1; 0 otherwise.
- Ready  out  1  one-cycle completion pulse.
- Err  out  1  coincides with Ready; access was out of range or had both strobes set.

## Operation
- FSM states IDLE, ACCESS, DONE. Reset state is IDLE. Reset values: Ready=0, Err=0, ReadData=0. The wait counter clears to 0.
- IDLE: if MemRead|MemWrite, capture DataAdr, WriteData, LSB, and the write flag (write = MemWrite) plus the error condition. Load the counter with WAIT_CYCLES and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: if counter≠0, decrement it and stay. If counter==0, perform the access and go to DONE.
- DONE: drive Ready=1. Drive ReadData from its register. Drive Err from the captured error condition. Go to IDLE unconditionally. Request inputs are ignored in ACCESS and DONE.
- Word index = DataAdr[31:2]. Out of range when the index ≥ DEPTH.
  - Out-of-range read returns 0.
  - Out-of-range write is dropped.
  - Err=1 in both cases.
- Word access ignores DataAdr[1:0].
- Byte load: ReadData = {24'b0, RAM[idx][8*a+7:8*a]}, where a = DataAdr[1:0].
- Byte store: read-modify-write. Only lane a is replaced, with WriteData[7:0]. The other three lanes are unchanged.
- Both MemRead and MemWrite high: treated as a write, and Err=1.
- RAM contents are not cleared by reset and are not initialised.

## Timing
- Request high in IDLE in cycle 0 → ACCESS from cycle 1 → Ready in cycle 2+WAIT_CYCLES. Minimum latency is 2 cycles.
- Write commits at the rising edge that ends the last ACCESS cycle. It is visible to a load issued after Ready.
- The requester holds its request stable until Ready and deasserts it in the Ready cycle.
- A request still high in the cycle after DONE is a new access. Back-to-back throughput is one access per 3+WAIT_CYCLES cycles.
- Reset in any state takes effect at the next edge:
  - state returns to IDLE;
  - a pending write is not committed;
  - no Ready pulse occurs for the aborted access.

## Configuration
- DMEM_RESP_BYTE_EN defined: LSB is honoured for loads and stores as described above.
- DMEM_RESP_BYTE_EN undefined:
  - LSB is ignored, and every access is a full word;
  - no read-modify-write path exists;
  - byte lane logic is not synthesised.

## Structure
- Package dmem_resp_pkg holds:
  - the state enum type (IDLE, ACCESS, DONE);
  - the counter width constant (4);
  - the lane-select helper function that extracts and replaces a byte lane.
- One sub-module, dmem_resp_ram: synchronous-write, registered-read DEPTH×32 array with a word enable. The FSM drives it only in the final ACCESS cycle.

## Test plan
- Reset, then word store 7 to 0x64 with WAIT_CYCLES=0. Expect Ready in cycle 2 with Err=0. A word load of 0x64 then returns ReadData=0x00000007 in its Ready cycle.
- Word store 0xAABBCCDD to 0x20, then byte store 0x11 to 0x22. A word load of 0x20 returns 0xAA11CCDD. A byte load of 0x23 returns 0x000000AA. Without the macro, the byte store overwrites the whole word with the full WriteData and the loads return words.
- WAIT_CYCLES=3: Ready first rises exactly 5 cycles after the request cycle. Ready is a single pulse, and ReadData=0 outside it.
- Load from 0x100 with DEPTH=64: ReadData=0 and Err=1 with Ready. A store to 0x100 leaves all RAM contents unchanged.
- MemRead and MemWrite both high, storing 0x5 to 0x8: Err=1, and a later load of 0x8 returns 0x5.
- Assert reset during ACCESS of a store of 0x9 to 0xC with WAIT_CYCLES=2. No Ready follows. A later load of 0xC returns the prior value, and the FSM accepts a new request the cycle after reset deasserts.
